// File: rtl/rc_cmd_parser.sv
// ---------------------------------------------------------------------------
// rc_cmd_parser
//
// Frames fixed-length RC command packets from a UART byte stream, validates
// them by checksum and publishes clamped attitude/height targets to the PID
// stage. A link watchdog forces a level-attitude failsafe when good packets
// stop arriving.
//
// Packet (11 bytes): 0xAA 0x55 | pitch[15:8] pitch[7:0] | roll | yaw | height | CHK
//   CHK = sum of the 8 payload bytes, mod 256.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   rx_valid       in   one-cycle strobe, rx_data valid
//   rx_data[7:0]   in   received byte
//   pitch_target   out  signed 0.01 deg, clamped to +/-ANGLE_LIMIT
//   roll_target    out  signed 0.01 deg, clamped to +/-ANGLE_LIMIT
//   yaw_target     out  signed yaw command, passed through
//   height_target  out  unsigned mm, passed through
//   target_valid   out  one-cycle pulse when targets update from a packet
//   link_lost      out  level, watchdog expired (1 out of reset)
//   good_cnt[7:0]  out  accepted packets, wraps
//   err_cnt[7:0]   out  rejected/aborted packets, saturates at 255
// ---------------------------------------------------------------------------
module rc_cmd_parser #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int LINK_TIMEOUT_MS = 100,
    parameter int BYTE_GAP_US     = 2000,
    parameter int ANGLE_LIMIT     = 3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic signed [15:0] pitch_target,
    output logic signed [15:0] roll_target,
    output logic signed [15:0] yaw_target,
    output logic [15:0]        height_target,
    output logic               target_valid,
    output logic               link_lost,
    output logic [7:0]         good_cnt,
    output logic [7:0]         err_cnt
);

    // Terminal counts computed in 64 bits: CLK_FREQ * BYTE_GAP_US overflows 32.
    localparam longint LINK_CYCLES = longint'(CLK_FREQ) * LINK_TIMEOUT_MS / 1000;
    localparam longint GAP_CYCLES  = longint'(CLK_FREQ) * BYTE_GAP_US / 1_000_000;

    localparam int LINK_W = $clog2(LINK_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [LINK_W-1:0] LINK_TERM = LINK_W'(LINK_CYCLES);
    localparam logic [LINK_W-1:0] LINK_LAST = LINK_W'(LINK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    localparam logic signed [15:0] LIM = 16'(ANGLE_LIMIT);

    typedef enum logic [1:0] {
        HUNT0,
        HUNT1,
        PAYLOAD,
        CHECK
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         buf_q [8];
    logic [7:0]         buf_d [8];
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [LINK_W-1:0]  link_cnt_q, link_cnt_d;
    logic signed [15:0] pitch_q, pitch_d;
    logic signed [15:0] roll_q, roll_d;
    logic signed [15:0] yaw_q, yaw_d;
    logic [15:0]        height_q, height_d;
    logic               target_valid_q, target_valid_d;
    logic               link_lost_q, link_lost_d;
    logic [7:0]         good_cnt_q, good_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic commit;
    logic gap_abort;
    logic link_expire;

    function automatic logic signed [15:0] clamp_angle(input logic signed [15:0] v);
        if (v > LIM) begin
            return LIM;
        end else if (v < -LIM) begin
            return -LIM;
        end
        return v;
    endfunction

    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        sum_d          = sum_q;
        buf_d          = buf_q;
        gap_cnt_d      = gap_cnt_q;
        link_cnt_d     = link_cnt_q;
        pitch_d        = pitch_q;
        roll_d         = roll_q;
        yaw_d          = yaw_q;
        height_d       = height_q;
        target_valid_d = 1'b0;
        link_lost_d    = link_lost_q;
        good_cnt_d     = good_cnt_q;
        err_cnt_d      = err_cnt_q;
        commit         = 1'b0;
        gap_abort      = 1'b0;

        // Byte-gap timer: idle while hunting, restarted by every byte. A byte
        // on the terminal cycle wins over the abort.
        if (state_q == HUNT0 || rx_valid) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
            gap_abort = 1'b1;
            gap_cnt_d = '0;
        end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end

        if (rx_valid) begin
            unique case (state_q)
                HUNT0: begin
                    if (rx_data == 8'hAA) state_d = HUNT1;
                end
                HUNT1: begin
                    if (rx_data == 8'h55) begin
                        state_d = PAYLOAD;
                        idx_d   = '0;
                        sum_d   = '0;
                    end else if (rx_data != 8'hAA) begin
                        state_d = HUNT0;
                    end
                end
                PAYLOAD: begin
                    buf_d[idx_q] = rx_data;
                    sum_d        = sum_q + rx_data;
                    idx_d        = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = CHECK;
                end
                CHECK: begin
                    if (rx_data == sum_q) begin
                        commit = 1'b1;
                    end else if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = HUNT0;
                end
                default: state_d = HUNT0;
            endcase
        end else if (gap_abort) begin
            // Partial payload left in buf_q is simply overwritten by the next packet.
            state_d = HUNT0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end

        // Link watchdog: saturates at the terminal count so it fires once.
        link_expire = !commit && (link_cnt_q == LINK_LAST);
        if (commit) begin
            link_cnt_d = '0;
        end else if (link_cnt_q != LINK_TERM) begin
            link_cnt_d = link_cnt_q + LINK_W'(1);
        end

        if (link_expire) begin
            link_lost_d = 1'b1;
            pitch_d     = '0;
            roll_d      = '0;
            yaw_d       = '0;
        end

        if (commit) begin
            pitch_d        = clamp_angle({buf_q[0], buf_q[1]});
            roll_d         = clamp_angle({buf_q[2], buf_q[3]});
            yaw_d          = {buf_q[4], buf_q[5]};
            height_d       = {buf_q[6], buf_q[7]};
            target_valid_d = 1'b1;
            good_cnt_d     = good_cnt_q + 8'd1;
            link_lost_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= HUNT0;
            idx_q          <= '0;
            sum_q          <= '0;
            // NOTE: the 8-byte payload buffer is small enough to reset as
            // flops; a real RAM would be left unreset.
            for (int i = 0; i < 8; i++) buf_q[i] <= '0;
            gap_cnt_q      <= '0;
            link_cnt_q     <= '0;
            pitch_q        <= '0;
            roll_q         <= '0;
            yaw_q          <= '0;
            height_q       <= '0;
            target_valid_q <= 1'b0;
            link_lost_q    <= 1'b1;
            good_cnt_q     <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            sum_q          <= sum_d;
            buf_q          <= buf_d;
            gap_cnt_q      <= gap_cnt_d;
            link_cnt_q     <= link_cnt_d;
            pitch_q        <= pitch_d;
            roll_q         <= roll_d;
            yaw_q          <= yaw_d;
            height_q       <= height_d;
            target_valid_q <= target_valid_d;
            link_lost_q    <= link_lost_d;
            good_cnt_q     <= good_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign pitch_target  = pitch_q;
    assign roll_target   = roll_q;
    assign yaw_target    = yaw_q;
    assign height_target = height_q;
    assign target_valid  = target_valid_q;
    assign link_lost     = link_lost_q;
    assign good_cnt      = good_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_rc_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_rc_cmd_parser
//
// Self-checking bench for rc_cmd_parser. A scaled-down clock frequency keeps
// the watchdog (5000 cycles) and byte gap (200 cycles) short. A reference
// model tracks the packet under construction as a byte queue and elapsed
// cycle counts; all DUT outputs are compared against it every cycle, plus
// directed constant checks for the hand-built packets.
// ---------------------------------------------------------------------------
module tb_rc_cmd_parser;

    localparam int CLK_FREQ = 100_000;
    localparam int LINK_MS  = 50;
    localparam int GAP_US   = 2000;
    localparam int LIMIT    = 3000;
    localparam int W        = CLK_FREQ / 1000 * LINK_MS;        // watchdog cycles
    localparam int G        = CLK_FREQ / 1000 * GAP_US / 1000;  // byte-gap cycles

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] pitch_target, roll_target, yaw_target, height_target;
    logic        target_valid, link_lost;
    logic [7:0]  good_cnt, err_cnt;

    rc_cmd_parser #(
        .CLK_FREQ       (CLK_FREQ),
        .LINK_TIMEOUT_MS(LINK_MS),
        .BYTE_GAP_US    (GAP_US),
        .ANGLE_LIMIT    (LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .pitch_target (pitch_target),
        .roll_target  (roll_target),
        .yaw_target   (yaw_target),
        .height_target(height_target),
        .target_valid (target_valid),
        .link_lost    (link_lost),
        .good_cnt     (good_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  frame[$];      // header + payload bytes of the packet in flight
    int          idle;          // cycles since last byte while a packet is in flight
    int          age;           // cycles since last commit/reset, saturating at W
    logic [15:0] m_pitch, m_roll, m_yaw, m_height;
    logic        m_tv, m_ll;
    int          m_good, m_err;

    function automatic logic [15:0] clamp(input logic [15:0] raw);
        int v;
        v = int'($signed(raw));
        if (v > LIMIT) return 16'(LIMIT);
        if (v < -LIMIT) return 16'(-LIMIT);
        return raw;
    endfunction

    task automatic model_reset();
        frame.delete();
        idle     = 0;
        age      = 0;
        m_pitch  = '0;
        m_roll   = '0;
        m_yaw    = '0;
        m_height = '0;
        m_tv     = 1'b0;
        m_ll     = 1'b1;
        m_good   = 0;
        m_err    = 0;
    endtask

    task automatic err_inc();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d);
        bit         commit;
        logic [7:0] s;
        commit = 1'b0;
        m_tv   = 1'b0;
        if (v) begin
            idle = 0;
            if (frame.size() == 0) begin
                if (d == 8'hAA) frame.push_back(d);
            end else if (frame.size() == 1) begin
                if (d == 8'h55) frame.push_back(d);
                else if (d != 8'hAA) frame.delete();
            end else if (frame.size() == 10) begin
                s = 8'h00;
                for (int i = 2; i < 10; i++) s = s + frame[i];
                if (s == d) begin
                    commit   = 1'b1;
                    m_pitch  = clamp({frame[2], frame[3]});
                    m_roll   = clamp({frame[4], frame[5]});
                    m_yaw    = {frame[6], frame[7]};
                    m_height = {frame[8], frame[9]};
                    m_tv     = 1'b1;
                    m_good   = (m_good + 1) % 256;
                    m_ll     = 1'b0;
                end else begin
                    err_inc();
                end
                frame.delete();
            end else begin
                frame.push_back(d);
            end
        end else if (frame.size() > 0) begin
            idle++;
            if (idle >= G) begin
                frame.delete();
                idle = 0;
                err_inc();
            end
        end
        if (commit) begin
            age = 0;
        end else if (age < W) begin
            age++;
            if (age == W) begin
                m_ll    = 1'b1;
                m_pitch = '0;
                m_roll  = '0;
                m_yaw   = '0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check(tag, {pitch_target, roll_target, yaw_target, height_target,
                    target_valid, link_lost, good_cnt, err_cnt},
                   {m_pitch, m_roll, m_yaw, m_height, m_tv, m_ll,
                    8'(m_good), 8'(m_err)});
    endtask

    // ---------------- stimulus ----------------
    // Called at a falling edge; drives one cycle, advances the model at the
    // rising edge and compares at the next falling edge.
    task automatic step(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        compare_all("cycle");
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        repeat (gap) step(1'b0, 8'h00);
        step(1'b1, d);
    endtask

    task automatic send_pkt(input logic [15:0] p, input logic [15:0] r,
                            input logic [15:0] y, input logic [15:0] h,
                            input bit bad, input int gap);
        logic [7:0] pl[8];
        logic [7:0] s;
        pl = '{p[15:8], p[7:0], r[15:8], r[7:0], y[15:8], y[7:0], h[15:8], h[7:0]};
        s  = 8'h00;
        for (int i = 0; i < 8; i++) s = s + pl[i];
        if (bad) s = s + 8'h01;
        send_byte(8'hAA, gap);
        send_byte(8'h55, gap);
        for (int i = 0; i < 8; i++) send_byte(pl[i], gap);
        send_byte(s, gap);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("reset_state");
        check("reset_link_lost", link_lost, 1'b1);
        reset = 1'b0;

        // Silence past the watchdog: link_lost stays high, nothing counted.
        idle_cycles(W + 1);
        check("silence_err_cnt", err_cnt, 8'd0);
        check("silence_pitch", pitch_target, 16'h0000);

        // Reference packet. Its payload sums to 0x4E, so 0x4E is the valid
        // checksum and 0x4D is a corrupted one.
        send_byte(8'hAA, 0); send_byte(8'h55, 0);
        send_byte(8'h01, 0); send_byte(8'hF4, 0); send_byte(8'hFE, 0); send_byte(8'h0C, 0);
        send_byte(8'h00, 0); send_byte(8'h64, 0); send_byte(8'h03, 0); send_byte(8'hE8, 0);
        send_byte(8'h4E, 0);
        check("pkt1_valid", target_valid, 1'b1);
        check("pkt1_pitch", pitch_target, 16'd500);
        check("pkt1_roll", roll_target, 16'hFE0C);
        check("pkt1_yaw", yaw_target, 16'd100);
        check("pkt1_height", height_target, 16'd1000);
        check("pkt1_link", link_lost, 1'b0);
        check("pkt1_good", good_cnt, 8'd1);
        step(1'b0, 8'h00);
        check("pkt1_pulse_width", target_valid, 1'b0);

        // Bad checksum: rejected, targets untouched.
        send_pkt(16'h01F4, 16'hFE0C, 16'h0064, 16'h03E8, 1'b1, 0);
        check("badchk_valid", target_valid, 1'b0);
        check("badchk_err", err_cnt, 8'd1);
        check("badchk_pitch", pitch_target, 16'd500);
        send_pkt(16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b0, 1);
        check("after_bad_good", good_cnt, 8'd2);

        // Clamp.
        send_pkt(16'h1388, 16'hEC78, 16'h8000, 16'hFFFF, 1'b0, 0);
        check("clamp_pitch", pitch_target, 16'd3000);
        check("clamp_roll", roll_target, 16'hF448);
        check("clamp_yaw", yaw_target, 16'h8000);

        // Repeated header resync.
        send_byte(8'hAA, 0);
        send_pkt(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0, 0);
        check("resync_valid", target_valid, 1'b1);
        check("resync_good", good_cnt, 8'd4);

        // Byte arriving on the last allowed cycle is accepted.
        send_pkt(16'h0101, 16'h0202, 16'h0303, 16'h0404, 1'b0, G - 1);
        check("gap_edge_ok", good_cnt, 8'd5);

        // Truncated packet, then silence: aborted.
        send_byte(8'hAA, 0); send_byte(8'h55, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h11, 0);
        idle_cycles(G + 5);
        check("gap_abort_err", err_cnt, 8'd2);
        send_pkt(16'h0000, 16'h0000, 16'h0000, 16'd1000, 1'b0, 0);
        check("post_abort_good", good_cnt, 8'd6);

        // Gap of exactly G cycles aborts.
        send_byte(8'hAA, 0); send_byte(8'h55, 0);
        idle_cycles(G);
        check("gap_exact_err", err_cnt, 8'd3);

        // Watchdog after a commit with height=1000.
        send_pkt(16'h0200, 16'hFE00, 16'h0050, 16'd1000, 1'b0, 0);
        for (int n = 0; n < 2 * W && !link_lost; n++) step(1'b0, 8'h00);
        check("wd_link", link_lost, 1'b1);
        check("wd_pitch", pitch_target, 16'h0000);
        check("wd_yaw", yaw_target, 16'h0000);
        check("wd_height", height_target, 16'd1000);
        check("wd_no_pulse", target_valid, 1'b0);

        // Commit landing on the watchdog expiry cycle.
        send_pkt(16'h0005, 16'h0006, 16'h0007, 16'h0008, 1'b0, 0);
        for (int n = 0; n < 2 * W && age < W - 11; n++) step(1'b0, 8'h00);
        send_pkt(16'h0009, 16'h000A, 16'h000B, 16'h000C, 1'b0, 0);
        check("race_link", link_lost, 1'b0);
        check("race_valid", target_valid, 1'b1);
        check("race_pitch", pitch_target, 16'h0009);

        // Error counter saturation and good counter wrap.
        for (int i = 0; i < 260; i++) send_pkt(16'(i), 16'h0, 16'h0, 16'h0, 1'b1, 0);
        check("err_saturate", err_cnt, 8'd255);
        for (int i = 0; i < 260; i++) send_pkt(16'(i), 16'h0, 16'h0, 16'h0, 1'b0, 0);

        // Randomized traffic.
        for (int it = 0; it < 150; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: for (int j = 0; j < int'($urandom_range(1, 6)); j++)
                       send_byte(8'($urandom), int'($urandom_range(0, 2)));
                1: send_pkt(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                            1'b1, int'($urandom_range(0, 2)));
                2: begin
                    send_byte(8'hAA, 0);
                    send_byte(8'h55, 0);
                    for (int j = 0; j < int'($urandom_range(0, 8)); j++)
                        send_byte(8'($urandom), 0);
                    idle_cycles(G - 2 + int'($urandom_range(0, 4)));
                end
                3: idle_cycles(int'($urandom_range(100, 1500)));
                default: send_pkt(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                                  1'b0, ($urandom_range(0, 19) == 0) ? G - 1
                                                                     : int'($urandom_range(0, 2)));
            endcase
        end

        // Reset mid-payload.
        send_pkt(16'h0033, 16'h0044, 16'h0055, 16'h0066, 1'b0, 0);
        send_byte(8'hAA, 0); send_byte(8'h55, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all("midreset_state");
        check("midreset_link", link_lost, 1'b1);
        check("midreset_good", good_cnt, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 8'hA9)), 0);
        send_pkt(16'h0777, 16'h0888, 16'h0999, 16'h0AAA, 1'b0, 0);
        check("post_reset_good", good_cnt, 8'd1);
        check("post_reset_pitch", pitch_target, 16'h0777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
